ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; the consumer of the ID-to-EX bus.
- Registers the decoded bundle under the stall vector, then computes the ALU result from the one-hot source selects and the 12-bit one-hot alu_op.
- Issues the data-SRAM request for lw/sw and drives EX-stage forwarding (ex_wreg/ex_waddr/ex_wdata) plus the load-in-EX flag (ex_opl) back to ID.
- Passes results to MEM on ex_to_mem_bus.

---
 rtl/ex_stage_pkg.sv | 72 +++++++
 rtl/ex_stage_alu.sv | 29 ++
 rtl/ex_stage.sv | 98 +++++++++
 tb/tb_ex_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, stall encoding,
// one-hot alu_op / source-select bit positions and the packed bus layouts.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int STALL_WD     = 6;

  typedef logic [STALL_WD-1:0] stall_bus_t;

  // Stall vector encoding: a 1 in a stage's bit stops that stage.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Stall bits that matter to EX: bit 2 holds the ID/EX register,
  // bit 3 holds the stage after it.
  localparam int STALL_EX  = 2;
  localparam int STALL_MEM = 3;

  // alu_op bit positions, MSB to LSB.
  localparam int OP_ADD  = 11;
  localparam int OP_SUB  = 10;
  localparam int OP_SLT  = 9;
  localparam int OP_SLTU = 8;
  localparam int OP_AND  = 7;
  localparam int OP_NOR  = 6;
  localparam int OP_OR   = 5;
  localparam int OP_XOR  = 4;
  localparam int OP_SLL  = 3;
  localparam int OP_SRL  = 2;
  localparam int OP_SRA  = 1;
  localparam int OP_LUI  = 0;

  // src1 select bits.
  localparam int SRC1_RS = 0;
  localparam int SRC1_PC = 1;
  localparam int SRC1_SA = 2;

  // src2 select bits.
  localparam int SRC2_RT    = 0;
  localparam int SRC2_SIMM  = 1;
  localparam int SRC2_EIGHT = 2;
  localparam int SRC2_ZIMM  = 3;

  // Decoded bundle from ID; field order matches the ID-to-EX bus, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  src1_sel;
    logic [3:0]  src2_sel;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  // Bundle handed to MEM, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
  } ex_to_mem_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU driven by a one-hot operation select.
// Kept free of state so multi-cycle units can reuse it.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);

  // Pick the result of the single active operation; none active gives 0.
  always_comb begin
    result = 32'd0;
    if (alu_op[OP_ADD])       result = src1 + src2;
    else if (alu_op[OP_SUB])  result = src1 - src2;
    else if (alu_op[OP_SLT])  result = {31'd0, $signed(src1) < $signed(src2)};
    else if (alu_op[OP_SLTU]) result = {31'd0, src1 < src2};
    else if (alu_op[OP_AND])  result = src1 & src2;
    else if (alu_op[OP_NOR])  result = ~(src1 | src2);
    else if (alu_op[OP_OR])   result = src1 | src2;
    else if (alu_op[OP_XOR])  result = src1 ^ src2;
    else if (alu_op[OP_SLL])  result = src2 << src1[4:0];
    else if (alu_op[OP_SRL])  result = src2 >> src1[4:0];
    else if (alu_op[OP_SRA])  result = $signed(src2) >>> src1[4:0];
    else if (alu_op[OP_LUI])  result = {src2[15:0], 16'd0};
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: registers the ID bundle under the stall vector, runs the
// ALU, issues the data-SRAM request and feeds forwarding info back to ID.
// Stall semantics: stall[2]=1 stops the ID/EX register; with stall[3]=0 a
// bubble enters EX, with stall[3]=1 EX holds its current instruction and
// keeps its SRAM request and forwarding outputs asserted.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    ex_wreg,
  output logic [4:0]              ex_waddr,
  output logic [31:0]             ex_wdata,
  output logic                    ex_opl
);

  id_to_ex_t  ex_r;
  id_to_ex_t  bus_in;
  ex_to_mem_t mem_out;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] result;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_bits;

  assign bus_in   = id_to_ex_bus;
  assign imm_sext = {{16{ex_r.inst[15]}}, ex_r.inst[15:0]};
  assign imm_zext = {16'd0, ex_r.inst[15:0]};

  // Stall bits owned by other stages and the opcode/register fields of inst
  // are not needed here.
  assign unused_bits = ^{stall[5:4], stall[1:0], ex_r.inst[31:16]};

  // ID/EX register: reset wins, then bubble, then capture, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= '0;
    end else if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NO_STOP) begin
      ex_r <= '0;
    end else if (stall[STALL_EX] == NO_STOP) begin
      ex_r <= bus_in;
    end
  end

  // First operand from its one-hot select.
  always_comb begin
    src1 = 32'd0;
    if (ex_r.src1_sel[SRC1_RS])      src1 = ex_r.rdata1;
    else if (ex_r.src1_sel[SRC1_PC]) src1 = ex_r.pc;
    else if (ex_r.src1_sel[SRC1_SA]) src1 = {27'd0, ex_r.inst[10:6]};
  end

  // Second operand from its one-hot select.
  always_comb begin
    src2 = 32'd0;
    if (ex_r.src2_sel[SRC2_RT])         src2 = ex_r.rdata2;
    else if (ex_r.src2_sel[SRC2_SIMM])  src2 = imm_sext;
    else if (ex_r.src2_sel[SRC2_EIGHT]) src2 = 32'd8;
    else if (ex_r.src2_sel[SRC2_ZIMM])  src2 = imm_zext;
  end

  ex_stage_alu u_alu (
    .alu_op (ex_r.alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (result)
  );

  assign mem_out.pc         = ex_r.pc;
  assign mem_out.ram_en     = ex_r.ram_en;
  assign mem_out.ram_wen    = ex_r.ram_wen;
  assign mem_out.sel_rf_res = ex_r.sel_rf_res;
  assign mem_out.rf_we      = ex_r.rf_we;
  assign mem_out.rf_waddr   = ex_r.rf_waddr;
  assign mem_out.result     = result;
  assign ex_to_mem_bus      = mem_out;

  // Load/store address is the ALU sum rdata1 + sext(imm).
  assign data_sram_en    = ex_r.ram_en;
  assign data_sram_wen   = ex_r.ram_wen;
  assign data_sram_addr  = result;
  assign data_sram_wdata = ex_r.rdata2;

  // For a load, ex_wdata is only the address; ID must check ex_opl.
  assign ex_wreg  = ex_r.rf_we;
  assign ex_waddr = ex_r.rf_waddr;
  assign ex_wdata = result;
  assign ex_opl   = ex_r.sel_rf_res;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a bench-side model of the ID/EX register
// and ALU pushes expected outputs to a queue, compared one cycle later.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   stall = 6'd0;
  logic [158:0] id_to_ex_bus = '0;
  logic [75:0]  ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_wreg;
  logic [4:0]   ex_waddr;
  logic [31:0]  ex_wdata;
  logic         ex_opl;

  typedef struct packed {
    logic [75:0] mem_bus;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] fwd;
    logic        opl;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  exp_t mdl = '0;
  int   n_checks = 0;
  int   n_pass = 0;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .ex_wreg         (ex_wreg),
    .ex_waddr        (ex_waddr),
    .ex_wdata        (ex_wdata),
    .ex_opl          (ex_opl)
  );

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [158:0] mk_bus(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
    input logic [2:0] s1, input logic [3:0] s2, input logic ren,
    input logic [3:0] wen, input logic we, input logic [4:0] wa,
    input logic sel, input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, ren, wen, we, wa, sel, r1, r2};
  endfunction

  function automatic exp_t exp_of(input logic [158:0] b, input logic [31:0] res);
    exp_t e;
    e.mem_bus = {b[158:127], b[75], b[74:71], b[64], b[70], b[69:65], res};
    e.en      = b[75];
    e.wen     = b[74:71];
    e.addr    = res;
    e.wdata   = b[31:0];
    e.wreg    = b[70];
    e.waddr   = b[69:65];
    e.fwd     = res;
    e.opl     = b[64];
    return e;
  endfunction

  // Reference ALU written from the instruction-set view of each operation.
  function automatic logic [31:0] ref_alu(input logic [158:0] b);
    logic [31:0] pc, inst, r1, r2, a, c, r;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    pc = b[158:127]; inst = b[126:95]; op = b[94:83];
    s1 = b[82:80]; s2 = b[79:76]; r1 = b[63:32]; r2 = b[31:0];
    case (s1)
      3'b001:  a = r1;
      3'b010:  a = pc;
      3'b100:  a = {27'd0, inst[10:6]};
      default: a = 32'd0;
    endcase
    case (s2)
      4'b0001: c = r2;
      4'b0010: c = {{16{inst[15]}}, inst[15:0]};
      4'b0100: c = 32'd8;
      4'b1000: c = {16'd0, inst[15:0]};
      default: c = 32'd0;
    endcase
    case (op)
      12'h800: r = a + c;
      12'h400: r = a - c;
      12'h200: r = ($signed(a) < $signed(c)) ? 32'd1 : 32'd0;
      12'h100: r = (a < c) ? 32'd1 : 32'd0;
      12'h080: r = a & c;
      12'h040: r = ~(a | c);
      12'h020: r = a | c;
      12'h010: r = a ^ c;
      12'h008: r = c << a[4:0];
      12'h004: r = c >> a[4:0];
      12'h002: r = $signed(c) >>> a[4:0];
      12'h001: r = {c[15:0], 16'd0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // scoreboard: pop one expected record and compare every output
  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL queue: got empty expected queue, required one entry");
    end else begin
      e = exp_t'(exp_q.pop_front());
      check("mem_bus", ex_to_mem_bus, e.mem_bus);
      check("sram_en", 76'(data_sram_en), 76'(e.en));
      check("sram_wen", 76'(data_sram_wen), 76'(e.wen));
      check("sram_addr", 76'(data_sram_addr), 76'(e.addr));
      check("sram_wdata", 76'(data_sram_wdata), 76'(e.wdata));
      check("ex_wreg", 76'(ex_wreg), 76'(e.wreg));
      check("ex_waddr", 76'(ex_waddr), 76'(e.waddr));
      check("ex_wdata", 76'(ex_wdata), 76'(e.fwd));
      check("ex_opl", 76'(ex_opl), 76'(e.opl));
    end
  endtask

  // driver: present one cycle of stimulus, update the model, check after the edge
  task automatic step(input logic [158:0] b, input logic [5:0] st, input logic r,
                      input logic [31:0] res);
    @(negedge clk);
    id_to_ex_bus = b;
    stall        = st;
    rst          = r;
    if (r) mdl = '0;
    else if (st[2] && !st[3]) mdl = '0;
    else if (!st[2]) mdl = exp_of(b, res);
    exp_q.push_back(EXP_W'(mdl));
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    logic [158:0] b;
    logic [158:0] addu_b;
    logic [158:0] lw_b;
    logic [11:0]  op;
    logic [2:0]   s1;
    logic [3:0]   s2;
    logic [5:0]   st;
    logic [3:0]   k;

    addu_b = mk_bus(32'hBFC00010, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0,
                    1'b1, 5'd5, 1'b0, 32'h7FFFFFFF, 32'h1);
    // reset with a live bundle on the bus: everything reads 0
    step(addu_b, 6'd0, 1'b1, 32'h80000000);
    step(addu_b, 6'd0, 1'b1, 32'h80000000);

    // addu wraps into the sign bit
    step(addu_b, 6'd0, 1'b0, 32'h80000000);

    // sw: address rdata1 + sext(0xFFFC)
    b = mk_bus(32'hBFC00014, 32'hAC00FFFC, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF,
               1'b0, 5'd0, 1'b0, 32'h00001000, 32'hDEADBEEF);
    step(b, 6'd0, 1'b0, 32'h00000FFC);

    // sra by sa=4
    b = mk_bus(32'hBFC00018, 32'h00000100, 12'h002, 3'b100, 4'b0001, 1'b0, 4'h0,
               1'b1, 5'd9, 1'b0, 32'h0, 32'h80000010);
    step(b, 6'd0, 1'b0, 32'hF8000001);

    // lui 0x1234
    b = mk_bus(32'hBFC0001C, 32'h3C011234, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0,
               1'b1, 5'd1, 1'b0, 32'h0, 32'h0);
    step(b, 6'd0, 1'b0, 32'h12340000);

    // sltu / slt on 1 vs 0xFFFFFFFF
    b = mk_bus(32'hBFC00020, 32'h0, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0,
               1'b1, 5'd2, 1'b0, 32'h1, 32'hFFFFFFFF);
    step(b, 6'd0, 1'b0, 32'h1);
    b = mk_bus(32'hBFC00024, 32'h0, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0,
               1'b1, 5'd3, 1'b0, 32'h1, 32'hFFFFFFFF);
    step(b, 6'd0, 1'b0, 32'h0);

    // lw enters EX, then is held twice, then replaced by a bubble
    lw_b = mk_bus(32'hBFC00028, 32'h8C080010, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0,
                  1'b1, 5'd8, 1'b1, 32'h00002000, 32'h0);
    step(lw_b, 6'd0, 1'b0, 32'h00002010);
    step(addu_b, 6'b001111, 1'b0, 32'h80000000);
    step(addu_b, 6'b001111, 1'b0, 32'h80000000);
    step(addu_b, 6'b000111, 1'b0, 32'h80000000);

    // jal: pc + 8 into $31
    b = mk_bus(32'hBFC00000, 32'h0C000000, 12'h800, 3'b010, 4'b0100, 1'b0, 4'h0,
               1'b1, 5'd31, 1'b0, 32'h0, 32'h0);
    step(b, 6'd0, 1'b0, 32'hBFC00008);

    // stall[3] alone does not stop the capture
    step(addu_b, 6'b001000, 1'b0, 32'h80000000);

    // no op and no source selected gives 0
    b = mk_bus(32'hBFC00030, 32'hFFFFFFFF, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
               1'b1, 5'd4, 1'b0, 32'h12345678, 32'h9ABCDEF0);
    step(b, 6'd0, 1'b0, 32'h0);

    // reset during a hold clears the register
    step(lw_b, 6'd0, 1'b0, 32'h00002010);
    step(addu_b, 6'b001111, 1'b1, 32'h80000000);

    // random operations and stall patterns checked against the reference ALU
    for (int i = 0; i < 40; i++) begin
      k = 4'($urandom_range(0, 11));
      op = '0;
      op[k] = 1'b1;
      s1 = 3'b001 << $urandom_range(0, 2);
      s2 = 4'b0001 << $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0:       st = 6'b001111;
        1:       st = 6'b000111;
        2:       st = 6'b001000;
        default: st = 6'b000000;
      endcase
      b = mk_bus($urandom, $urandom, op, s1, s2, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom);
      step(b, st, 1'b0, ref_alu(b));
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
